// File: rtl/uart_tx_port_pkg.sv
// Shared definitions for the UART transmitter port: FSM encoding, CTRL bit
// positions and the default I/O map addresses.
package uart_tx_port_pkg;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_START  = 3'd1,
        ST_DATA   = 3'd2,
        ST_PARITY = 3'd3,
        ST_STOP   = 3'd4
    } tx_state_t;

    localparam int CTRL_READY = 0;
    localparam int CTRL_OVR   = 2;
    localparam int CTRL_PE    = 4;
    localparam int CTRL_IE    = 8;

    localparam logic [31:0] UART_TX_DATA_ADDR = 32'hF000_0200;
    localparam logic [31:0] UART_TX_DIV_ADDR  = 32'hF000_0204;
    localparam logic [31:0] UART_TX_CTRL_ADDR = 32'hF000_0208;

    // A divisor of zero would stall the timer, so it behaves as one.
    function automatic logic [15:0] eff_div(input logic [15:0] div);
        return (div == 16'd0) ? 16'd1 : div;
    endfunction

endpackage

// File: rtl/Register.sv
// Generic enabled register with a configurable synchronous reset value.
module Register #(
    parameter int           W       = 32,
    parameter logic [W-1:0] RST_VAL = '0
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         i_en,
    input  logic [W-1:0] i_d,
    output logic [W-1:0] o_q
);

    always_ff @(posedge clk) begin
        if (reset)
            o_q <= RST_VAL;
        else if (i_en)
            o_q <= i_d;
    end

endmodule

// File: rtl/uart_bit_timer.sv
// Bit-period timer: latches the divisor on load, then pulses o_tick on the
// last cycle of every DIV-cycle period while enabled.
module uart_bit_timer
    import uart_tx_port_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic        i_load,
    input  logic [15:0] i_div,
    input  logic        i_en,
    output logic        o_tick
);

    logic [15:0] r_div;
    logic [15:0] r_cnt;
    logic [15:0] w_div_eff;

    assign w_div_eff = eff_div(i_div);
    assign o_tick    = i_en && (r_cnt == 16'd0);

    always_ff @(posedge clk) begin
        if (reset) begin
            r_div <= 16'd1;
            r_cnt <= 16'd0;
        end else if (i_load) begin
            r_div <= w_div_eff;
            r_cnt <= w_div_eff - 16'd1;
        end else if (i_en) begin
            r_cnt <= (r_cnt == 16'd0) ? (r_div - 16'd1) : (r_cnt - 16'd1);
        end
    end

endmodule

// File: rtl/uart_tx_port.sv
// Memory-mapped 8N1 UART transmitter with a one-deep holding register.
// Optional even parity bit (CTRL.PE) is built when UART_TX_PARITY_EN is defined.
module uart_tx_port
    import uart_tx_port_pkg::*;
#(
    parameter int              BITS        = 32,
    parameter logic [BITS-1:0] BASE        = UART_TX_DATA_ADDR,
    parameter logic [BITS-1:0] DIV_BASE    = UART_TX_DIV_ADDR,
    parameter logic [BITS-1:0] CTRL_BASE   = UART_TX_CTRL_ADDR,
    parameter int              DEFAULT_DIV = 16
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            we,
    input  logic            re,
    input  logic [BITS-1:0] memAddr,
    input  logic [BITS-1:0] dataBusIn,
    output logic [BITS-1:0] dataBusOut,
    output logic            txd,
    output logic            intr
);

    logic w_wr_data, w_wr_div, w_wr_ctrl, w_rd_div, w_rd_ctrl;
    logic [15:0] w_div;
    logic [BITS-1:0] w_ctrl;
    logic w_unused;

    assign w_wr_data = we && (memAddr == BASE);
    assign w_wr_div  = we && (memAddr == DIV_BASE);
    assign w_wr_ctrl = we && (memAddr == CTRL_BASE);
    assign w_rd_div  = re && !we && (memAddr == DIV_BASE);
    assign w_rd_ctrl = re && !we && (memAddr == CTRL_BASE);
    assign w_unused  = ^dataBusIn[BITS-1:16];

    Register #(.W(16), .RST_VAL(16'(DEFAULT_DIV))) u_div_reg (
        .clk   (clk),
        .reset (reset),
        .i_en  (w_wr_div),
        .i_d   (dataBusIn[15:0]),
        .o_q   (w_div)
    );

    tx_state_t r_state, w_state_next;
    logic [7:0] r_hold, r_shift, w_shift_next;
    logic [2:0] r_bitcnt, w_bitcnt_next;
    logic       r_txd, w_txd_next;
    logic       r_ready, r_ovr, r_ie;
    logic       w_take, w_timer_en, w_tick;
`ifdef UART_TX_PARITY_EN
    logic       r_pe, r_par, w_par_next;
`endif

    uart_bit_timer u_timer (
        .clk    (clk),
        .reset  (reset),
        .i_load (w_take),
        .i_div  (w_div),
        .i_en   (w_timer_en),
        .o_tick (w_tick)
    );

    // Next-state logic; w_take moves the holding byte into the shifter and
    // restarts the bit timer at every start bit.
    always_comb begin
        w_state_next  = r_state;
        w_shift_next  = r_shift;
        w_bitcnt_next = r_bitcnt;
        w_txd_next    = r_txd;
        w_take        = 1'b0;
        w_timer_en    = (r_state != ST_IDLE);
`ifdef UART_TX_PARITY_EN
        w_par_next    = r_par;
`endif
        case (r_state)
            ST_IDLE: begin
                if (!r_ready) begin
                    w_take       = 1'b1;
                    w_state_next = ST_START;
                    w_txd_next   = 1'b0;
                end
            end
            ST_START: begin
                if (w_tick) begin
                    w_state_next = ST_DATA;
                    w_txd_next   = r_shift[0];
                    w_shift_next = {1'b0, r_shift[7:1]};
                end
            end
            ST_DATA: begin
                if (w_tick) begin
                    if (r_bitcnt == 3'd7) begin
                        w_state_next = ST_STOP;
                        w_txd_next   = 1'b1;
`ifdef UART_TX_PARITY_EN
                        if (r_pe) begin
                            w_state_next = ST_PARITY;
                            w_txd_next   = r_par;
                        end
`endif
                    end else begin
                        w_bitcnt_next = r_bitcnt + 3'd1;
                        w_txd_next    = r_shift[0];
                        w_shift_next  = {1'b0, r_shift[7:1]};
                    end
                end
            end
`ifdef UART_TX_PARITY_EN
            ST_PARITY: begin
                if (w_tick) begin
                    w_state_next = ST_STOP;
                    w_txd_next   = 1'b1;
                end
            end
`endif
            ST_STOP: begin
                if (w_tick) begin
                    if (!r_ready) begin
                        w_take       = 1'b1;
                        w_state_next = ST_START;
                        w_txd_next   = 1'b0;
                    end else begin
                        w_state_next = ST_IDLE;
                    end
                end
            end
            default: begin
                w_state_next = ST_IDLE;
                w_txd_next   = 1'b1;
            end
        endcase
        if (w_take) begin
            w_shift_next  = r_hold;
            w_bitcnt_next = 3'd0;
`ifdef UART_TX_PARITY_EN
            w_par_next    = ^r_hold;
`endif
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state  <= ST_IDLE;
            r_shift  <= 8'd0;
            r_bitcnt <= 3'd0;
            r_txd    <= 1'b1;
            r_hold   <= 8'd0;
            r_ready  <= 1'b1;
            r_ovr    <= 1'b0;
            r_ie     <= 1'b0;
`ifdef UART_TX_PARITY_EN
            r_pe     <= 1'b0;
            r_par    <= 1'b0;
`endif
        end else begin
            r_state  <= w_state_next;
            r_shift  <= w_shift_next;
            r_bitcnt <= w_bitcnt_next;
            r_txd    <= w_txd_next;
`ifdef UART_TX_PARITY_EN
            r_par    <= w_par_next;
            if (w_wr_ctrl)
                r_pe <= dataBusIn[CTRL_PE];
`endif
            // A transfer only happens with holding full, so it never collides
            // with an accepted DATA write.
            if (w_wr_data && r_ready) begin
                r_hold  <= dataBusIn[7:0];
                r_ready <= 1'b0;
            end else if (w_take) begin
                r_ready <= 1'b1;
            end
            if (w_wr_data && !r_ready)
                r_ovr <= 1'b1;
            else if (w_wr_ctrl && !dataBusIn[CTRL_OVR])
                r_ovr <= 1'b0;
            if (w_wr_ctrl)
                r_ie <= dataBusIn[CTRL_IE];
        end
    end

    always_comb begin
        w_ctrl             = '0;
        w_ctrl[CTRL_READY] = r_ready;
        w_ctrl[CTRL_OVR]   = r_ovr;
        w_ctrl[CTRL_IE]    = r_ie;
`ifdef UART_TX_PARITY_EN
        w_ctrl[CTRL_PE]    = r_pe;
`endif
    end

    always_comb begin
        dataBusOut = '0;
        if (w_rd_div)
            dataBusOut = {{(BITS-16){1'b0}}, w_div};
        else if (w_rd_ctrl)
            dataBusOut = w_ctrl;
    end

    assign txd  = r_txd;
    assign intr = r_ie && r_ready;

endmodule

// File: tb/tb_uart_tx_port.sv
// Directed self-checking bench for uart_tx_port; parity scenario runs when
// UART_TX_PARITY_EN is defined.
module tb_uart_tx_port;

    localparam logic [31:0] DATA_A = 32'hF000_0200;
    localparam logic [31:0] DIV_A  = 32'hF000_0204;
    localparam logic [31:0] CTRL_A = 32'hF000_0208;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        we = 1'b0;
    logic        re = 1'b0;
    logic [31:0] memAddr = '0;
    logic [31:0] dataBusIn = '0;
    logic [31:0] dataBusOut;
    logic        txd, intr;

    int total = 0;
    int bad   = 0;

    uart_tx_port dut (
        .clk        (clk),
        .reset      (reset),
        .we         (we),
        .re         (re),
        .memAddr    (memAddr),
        .dataBusIn  (dataBusIn),
        .dataBusOut (dataBusOut),
        .txd        (txd),
        .intr       (intr)
    );

    always #5 clk = ~clk;

    task automatic tick_n(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic bus_wr(input logic [31:0] a, input logic [31:0] d);
        memAddr = a; dataBusIn = d; we = 1'b1;
        @(posedge clk);
        #1;
        we = 1'b0; memAddr = '0; dataBusIn = '0;
    endtask

    task automatic bus_rd(output logic [31:0] v, input logic [31:0] a);
        memAddr = a; re = 1'b1;
        #1;
        v = dataBusOut;
        re = 1'b0; memAddr = '0;
    endtask

    task automatic test_reset();
        logic [31:0] v;
        reset = 1'b1;
        tick_n(2);
        reset = 1'b0;
        tick_n(1);
        total++; if (txd !== 1'b1) begin bad++; $display("FAIL reset_txd got %b want 1", txd); end
        total++; if (intr !== 1'b0) begin bad++; $display("FAIL reset_intr got %b want 0", intr); end
        bus_rd(v, CTRL_A);
        total++; if (v !== 32'h001) begin bad++; $display("FAIL reset_ctrl got %h want 001", v); end
        bus_rd(v, DIV_A);
        total++; if (v !== 32'd16) begin bad++; $display("FAIL reset_div got %0d want 16", v); end
        memAddr = CTRL_A;
        #1;
        total++; if (dataBusOut !== 32'h0) begin bad++; $display("FAIL unselected_out got %h want 0", dataBusOut); end
        memAddr = '0;
        bus_rd(v, DATA_A);
        total++; if (v !== 32'h0) begin bad++; $display("FAIL data_read got %h want 0", v); end
    endtask

    task automatic test_frame_55();
        logic [31:0] v;
        logic [9:0]  frame;
        logic        exp;
        frame = {1'b1, 8'h55, 1'b0};
        bus_wr(DIV_A, 32'hFFFF_0004);
        bus_rd(v, DIV_A);
        total++; if (v !== 32'h4) begin bad++; $display("FAIL div_upper got %h want 4", v); end
        bus_wr(DATA_A, 32'h55);
        bus_rd(v, CTRL_A);
        total++; if (v !== 32'h000) begin bad++; $display("FAIL f55_busy_ctrl got %h want 000", v); end
        total++; if (txd !== 1'b1) begin bad++; $display("FAIL f55_pre_txd got %b want 1", txd); end
        tick_n(1);
        bus_rd(v, CTRL_A);
        total++; if (v !== 32'h001) begin bad++; $display("FAIL f55_ready_back got %h want 001", v); end
        for (int i = 0; i < 40; i++) begin
            exp = frame[i / 4];
            total++; if (txd !== exp) begin bad++; $display("FAIL f55_txd cyc=%0d got %b want %b", i, txd, exp); end
            tick_n(1);
        end
        total++; if (txd !== 1'b1) begin bad++; $display("FAIL f55_idle_txd got %b want 1", txd); end
    endtask

    task automatic test_back_to_back();
        logic [31:0] v;
        logic [19:0] stream;
        logic        exp;
        stream = {1'b1, 8'h0F, 1'b0, 1'b1, 8'hA3, 1'b0};
        bus_wr(DIV_A, 32'd2);
        bus_wr(DATA_A, 32'hA3);
        tick_n(1);
        total++; if (txd !== 1'b0) begin bad++; $display("FAIL b2b_start got %b want 0", txd); end
        bus_wr(DATA_A, 32'h0F);
        for (int i = 1; i < 40; i++) begin
            exp = stream[i / 2];
            total++; if (txd !== exp) begin bad++; $display("FAIL b2b_txd cyc=%0d got %b want %b", i, txd, exp); end
            if (i == 10 || i == 19) begin
                bus_rd(v, CTRL_A);
                total++; if (v !== 32'h000) begin bad++; $display("FAIL b2b_busy cyc=%0d got %h want 000", i, v); end
            end
            if (i == 20) begin
                bus_rd(v, CTRL_A);
                total++; if (v !== 32'h001) begin bad++; $display("FAIL b2b_ready cyc=%0d got %h want 001", i, v); end
            end
            tick_n(1);
        end
        total++; if (txd !== 1'b1) begin bad++; $display("FAIL b2b_idle got %b want 1", txd); end
    endtask

    task automatic test_overrun();
        logic [31:0] v;
        logic [9:0]  frame;
        logic        exp;
        frame = {1'b1, 8'h22, 1'b0};
        bus_wr(DATA_A, 32'h11);
        tick_n(1);
        bus_wr(DATA_A, 32'h22);
        bus_wr(DATA_A, 32'h33);
        bus_rd(v, CTRL_A);
        total++; if (v !== 32'h004) begin bad++; $display("FAIL ovr_busy got %h want 004", v); end
        tick_n(20);
        bus_rd(v, CTRL_A);
        total++; if (v !== 32'h005) begin bad++; $display("FAIL ovr_sticky got %h want 005", v); end
        bus_wr(CTRL_A, 32'h000);
        bus_rd(v, CTRL_A);
        total++; if (v !== 32'h001) begin bad++; $display("FAIL ovr_clear got %h want 001", v); end
        // Second frame must carry 0x22; the dropped 0x33 must not appear.
        for (int j = 3; j < 20; j++) begin
            exp = frame[j / 2];
            total++; if (txd !== exp) begin bad++; $display("FAIL ovr_frame cyc=%0d got %b want %b", j, txd, exp); end
            tick_n(1);
        end
        tick_n(4);
    endtask

    task automatic test_intr_reset();
        logic [31:0] v;
        bus_wr(DIV_A, 32'd4);
        bus_wr(CTRL_A, 32'h100);
        total++; if (intr !== 1'b1) begin bad++; $display("FAIL intr_on got %b want 1", intr); end
        bus_rd(v, CTRL_A);
        total++; if (v !== 32'h101) begin bad++; $display("FAIL intr_ctrl got %h want 101", v); end
        bus_wr(DATA_A, 32'hB6);
        total++; if (intr !== 1'b0) begin bad++; $display("FAIL intr_busy got %b want 0", intr); end
        tick_n(1);
        total++; if (intr !== 1'b1) begin bad++; $display("FAIL intr_back got %b want 1", intr); end
        tick_n(17);
        total++; if (txd !== 1'b0) begin bad++; $display("FAIL mid_bit3 got %b want 0", txd); end
        reset = 1'b1;
        tick_n(1);
        total++; if (txd !== 1'b1) begin bad++; $display("FAIL abort_txd got %b want 1", txd); end
        reset = 1'b0;
        bus_rd(v, CTRL_A);
        total++; if (v !== 32'h001) begin bad++; $display("FAIL abort_ctrl got %h want 001", v); end
        bus_rd(v, DIV_A);
        total++; if (v !== 32'd16) begin bad++; $display("FAIL abort_div got %0d want 16", v); end
        total++; if (intr !== 1'b0) begin bad++; $display("FAIL abort_intr got %b want 0", intr); end
        tick_n(45);
        total++; if (txd !== 1'b1) begin bad++; $display("FAIL abort_quiet got %b want 1", txd); end
    endtask

`ifdef UART_TX_PARITY_EN
    task automatic test_parity();
        logic [31:0] v;
        logic [10:0] frame;
        logic        exp;
        bus_wr(DIV_A, 32'd1);
        bus_wr(CTRL_A, 32'h010);
        bus_rd(v, CTRL_A);
        total++; if (v !== 32'h011) begin bad++; $display("FAIL pe_ctrl got %h want 011", v); end
        for (int k = 0; k < 2; k++) begin
            frame = (k == 0) ? {1'b1, 1'b1, 8'h07, 1'b0} : {1'b1, 1'b0, 8'h03, 1'b0};
            bus_wr(DATA_A, (k == 0) ? 32'h07 : 32'h03);
            tick_n(1);
            for (int i = 0; i < 11; i++) begin
                exp = frame[i];
                total++; if (txd !== exp) begin bad++; $display("FAIL parity_frame%0d bit=%0d got %b want %b", k, i, txd, exp); end
                tick_n(1);
            end
            total++; if (txd !== 1'b1) begin bad++; $display("FAIL parity_idle%0d got %b want 1", k, txd); end
        end
    endtask
`else
    task automatic test_parity();
        logic [31:0] v;
        bus_wr(CTRL_A, 32'h010);
        bus_rd(v, CTRL_A);
        total++; if (v !== 32'h001) begin bad++; $display("FAIL pe_absent got %h want 001", v); end
    endtask
`endif

    initial begin
        test_reset();
        test_frame_55();
        test_back_to_back();
        test_overrun();
        test_intr_reset();
        test_parity();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
